// File: rtl/layer_compositor_pkg.sv
// Shared constants, fade FSM state type and the per-channel pixel scaler
// used by layer_compositor and its fade controller.
package layer_compositor_pkg;

   localparam logic [4:0]  FADE_LEVEL_MAX = 5'd16;
   localparam logic [4:0]  FADE_STEP      = 5'd2;
   localparam logic [11:0] COLOR_KEY      = 12'hF0F;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FADE_OUT = 2'd1,
      ST_HOLD     = 2'd2,
      ST_FADE_IN  = 2'd3
   } fade_state_e;

   // Each 4-bit channel becomes (c * level) >> 4; level 16 is unity gain.
   function automatic logic [11:0] scale_pixel(input logic [11:0] pix, input logic [4:0] level);
      logic [7:0]  prod;
      logic [11:0] res;
      res = '0;
      for (int ch = 0; ch < 3; ch++) begin
         prod = {4'b0, pix[4*ch +: 4]} * {3'b0, level};
         res[4*ch +: 4] = 4'(prod >> 4);
      end
      return res;
   endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// Pixel/fade bundle between the render engines (master) and layer_compositor (slave).
interface layer_compositor_if #(
   parameter int LAYERS = 5
) ();
   logic                     video_on;
   logic                     f_tick;
   logic [12*LAYERS-1:0]     layer_rgb;
   logic [LAYERS-1:0]        layer_on;
   logic                     fade_req;
   logic                     fade_resume;
   logic [11:0]              rgb;
   logic                     fade_busy;
   logic                     fade_black;
   logic                     fade_done;

   modport master (
      output video_on, f_tick, layer_rgb, layer_on, fade_req, fade_resume,
      input  rgb, fade_busy, fade_black, fade_done
   );

   modport slave (
      input  video_on, f_tick, layer_rgb, layer_on, fade_req, fade_resume,
      output rgb, fade_busy, fade_black, fade_done
   );
endinterface

// File: rtl/layer_compositor_fade_ctrl.sv
// Fade FSM: steps the brightness level by 2 every STEP_FRAMES frame ticks,
// fading to black, holding, then fading back in with a one-cycle done pulse.
module fade_ctrl
   import layer_compositor_pkg::*;
#(
   parameter int STEP_FRAMES = 2
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       f_tick,
   input  logic       fade_req,
   input  logic       fade_resume,
   output logic [4:0] level,
   output logic       fade_busy,
   output logic       fade_black,
   output logic       fade_done
);

   localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);

   fade_state_e state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [4:0]  level_q, level_d;
   logic        done_q, done_d;
   logic        step_now;

   assign step_now = f_tick && (cnt_q == STEP_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            level_d = FADE_LEVEL_MAX;
            if (fade_req) begin
               state_d = ST_FADE_OUT;
               cnt_d   = '0;
            end
         end
         ST_FADE_OUT: begin
            if (step_now) begin
               cnt_d   = '0;
               level_d = level_q - FADE_STEP;
               if (level_q == FADE_STEP) state_d = ST_HOLD;
            end else if (f_tick) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_HOLD: begin
            level_d = '0;
            if (fade_resume) begin
               state_d = ST_FADE_IN;
               cnt_d   = '0;
            end
         end
         ST_FADE_IN: begin
            if (step_now) begin
               cnt_d   = '0;
               level_d = level_q + FADE_STEP;
               if (level_q == FADE_LEVEL_MAX - FADE_STEP) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end else if (f_tick) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         level_q <= FADE_LEVEL_MAX;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         done_q  <= done_d;
      end
   end

   assign level      = level_q;
   assign fade_busy  = (state_q != ST_IDLE);
   assign fade_black = (state_q == ST_HOLD);
   assign fade_done  = done_q;

endmodule

// File: rtl/layer_compositor.sv
// Two-stage layer priority mux with fade scaling and video blanking.
// Define LAYER_COLOR_KEY_EN to treat 12'hF0F layer pixels as transparent.
module layer_compositor
   import layer_compositor_pkg::*;
#(
   parameter int          LAYERS      = 5,
   parameter int          STEP_FRAMES = 2,
   parameter logic [11:0] BG_COLOR    = 12'h000
) (
   input logic              clk,
   input logic              clr,
   layer_compositor_if.slave px
);

   logic [12*LAYERS-1:0] rgb_s1_q, rgb_s1_d;
   logic [LAYERS-1:0]    on_s1_q, on_s1_d;
   logic                 vid_s1_q, vid_s1_d;
   logic [11:0]          rgb_q, rgb_d;
   logic [LAYERS-1:0]    vis;
   logic [11:0]          sel;
   logic [4:0]           level;

   fade_ctrl #(.STEP_FRAMES(STEP_FRAMES)) u_fade (
      .clk        (clk),
      .clr        (clr),
      .f_tick     (px.f_tick),
      .fade_req   (px.fade_req),
      .fade_resume(px.fade_resume),
      .level      (level),
      .fade_busy  (px.fade_busy),
      .fade_black (px.fade_black),
      .fade_done  (px.fade_done)
   );

   // Visibility is resolved in S2 so both builds keep the same latency.
   generate
      for (genvar gi = 0; gi < LAYERS; gi++) begin : g_vis
`ifdef LAYER_COLOR_KEY_EN
         assign vis[gi] = on_s1_q[gi] && (rgb_s1_q[12*gi +: 12] != COLOR_KEY);
`else
         assign vis[gi] = on_s1_q[gi];
`endif
      end
   endgenerate

   always_comb begin
      rgb_s1_d = px.layer_rgb;
      on_s1_d  = px.layer_on;
      vid_s1_d = px.video_on;
      sel      = BG_COLOR;
      for (int i = 0; i < LAYERS; i++) begin
         if (vis[i]) sel = rgb_s1_q[12*i +: 12];
      end
      rgb_d = vid_s1_q ? scale_pixel(sel, level) : 12'h000;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rgb_s1_q <= '0;
         on_s1_q  <= '0;
         vid_s1_q <= 1'b0;
         rgb_q    <= '0;
      end else begin
         rgb_s1_q <= rgb_s1_d;
         on_s1_q  <= on_s1_d;
         vid_s1_q <= vid_s1_d;
         rgb_q    <= rgb_d;
      end
   end

   assign px.rgb = rgb_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Randomised scoreboard bench for layer_compositor: expected pixels and fade flags
// come from a tick-counting reference model and are checked by an independent monitor.
`timescale 1ns/1ps
module tb_layer_compositor;

   localparam int          LAYERS = 5;
   localparam int          STEP   = 2;
   localparam int          FRAME  = 6;
   localparam logic [11:0] BG     = 12'h35A;

   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   layer_compositor_if #(.LAYERS(LAYERS)) px ();

   layer_compositor #(.LAYERS(LAYERS), .STEP_FRAMES(STEP), .BG_COLOR(BG)) dut (
      .clk(clk),
      .clr(clr),
      .px (px)
   );

   typedef struct { int due; logic [11:0] rgb; string tag; } pix_exp_t;
   typedef struct { int due; logic [2:0] flags; string tag; } flag_exp_t;

   pix_exp_t  pix_q[$];
   flag_exp_t flag_q[$];
   int edge_cnt = 0;
   int n_cmp = 0;
   int n_bad = 0;

   // Reference fade model: mode 0 idle, 1 fading out, 2 black hold, 3 fading in.
   int m_mode  = 0;
   int m_ticks = 0;
   int m_level = 16;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp, input bit verbose);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s edge=%0d got=%h expected=%h", name, edge_cnt, got, exp);
      end else if (verbose) begin
         $display("txn %s edge=%0d value=%h ok", name, edge_cnt, got);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_ticks = 0; m_level = 16;
   endtask

   task automatic model_edge(input bit req, input bit res, input bit tick, output bit done);
      done = 1'b0;
      case (m_mode)
         0: if (req) begin m_mode = 1; m_ticks = 0; end
         1: if (tick) begin
               m_ticks++;
               m_level = 16 - 2 * (m_ticks / STEP);
               if (m_level == 0) m_mode = 2;
            end
         2: if (res) begin m_mode = 3; m_ticks = 0; end
         default: if (tick) begin
               m_ticks++;
               m_level = 2 * (m_ticks / STEP);
               if (m_level == 16) begin m_mode = 0; done = 1'b1; end
            end
      endcase
   endtask

   function automatic logic [11:0] ref_pixel(input logic vid, input logic [LAYERS-1:0] on,
                                             input logic [12*LAYERS-1:0] rgbs, input int level);
      logic [11:0] pix, c;
      int r, g, b;
      if (!vid) return 12'h000;
      pix = BG;
      for (int i = 0; i < LAYERS; i++) begin
         c = rgbs[12*i +: 12];
`ifdef LAYER_COLOR_KEY_EN
         if (on[i] && c != 12'hF0F) pix = c;
`else
         if (on[i]) pix = c;
`endif
      end
      r = int'(pix[11:8]) * level / 16;
      g = int'(pix[7:4]) * level / 16;
      b = int'(pix[3:0]) * level / 16;
      return {4'(r), 4'(g), 4'(b)};
   endfunction

   task automatic idle_inputs();
      px.video_on = 1'b0; px.f_tick = 1'b0; px.fade_req = 1'b0; px.fade_resume = 1'b0;
      px.layer_on = '0;   px.layer_rgb = '0;
   endtask

   task automatic drive(input logic vid, input logic [LAYERS-1:0] on, input logic [12*LAYERS-1:0] rgbs,
                        input bit tick, input bit req, input bit res, input string tag);
      bit        done;
      pix_exp_t  pe;
      flag_exp_t fe;
      @(posedge clk); #1;
      px.video_on = vid; px.layer_on = on; px.layer_rgb = rgbs;
      px.f_tick = tick;  px.fade_req = req; px.fade_resume = res;
      model_edge(req, res, tick, done);
      fe.due = edge_cnt + 1; fe.flags = {m_mode != 0, m_mode == 2, done}; fe.tag = tag;
      flag_q.push_back(fe);
      pe.due = edge_cnt + 2; pe.rgb = ref_pixel(vid, on, rgbs, m_level); pe.tag = tag;
      pix_q.push_back(pe);
   endtask

   // Monitor: output is presented every cycle, so each due entry is compared at the
   // falling edge after the rising edge it belongs to.
   pix_exp_t  mon_pe;
   flag_exp_t mon_fe;
   always @(negedge clk) begin
      if (!clr) begin
         while (flag_q.size() > 0 && flag_q[0].due <= edge_cnt) begin
            mon_fe = flag_q.pop_front();
            chk({mon_fe.tag, "_flags"}, {9'b0, px.fade_busy, px.fade_black, px.fade_done},
                {9'b0, mon_fe.flags}, 1'b0);
         end
         while (pix_q.size() > 0 && pix_q[0].due <= edge_cnt) begin
            mon_pe = pix_q.pop_front();
            chk({mon_pe.tag, "_rgb"}, px.rgb, mon_pe.rgb, mon_pe.tag != "rand");
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   localparam logic [12*LAYERS-1:0] PRIO_RGB  = {12'h444, 12'h333, 12'h222, 12'h111, 12'h000};
   localparam logic [12*LAYERS-1:0] WHITE_RGB = {48'h0, 12'hFFF};
   localparam logic [12*LAYERS-1:0] GREY_RGB  = {48'h0, 12'h888};
   localparam logic [12*LAYERS-1:0] KEY_RGB   = {12'hF0F, 12'h000, 12'h222, 12'h000, 12'h000};

   initial begin
      logic [12*LAYERS-1:0] rr;
      logic [11:0]          c;
      bit                   reached;
      idle_inputs();
      model_reset();
      @(posedge clk); #1;
      chk("reset_rgb", px.rgb, 12'h000, 1'b1);
      chk("reset_flags", {9'b0, px.fade_busy, px.fade_black, px.fade_done}, 12'h000, 1'b1);
      @(posedge clk); #1 clr = 1'b0;

      // Priority and background
      drive(1, 5'b10110, PRIO_RGB, 0, 0, 0, "prio");
      drive(1, 5'b00000, PRIO_RGB, 0, 0, 0, "bg");
      drive(1, 5'b00110, PRIO_RGB, 0, 0, 0, "prio");
      drive(1, 5'b00001, PRIO_RGB, 0, 0, 0, "prio");
      // Blanking and exact alignment around video_on edges
      drive(0, 5'b11111, PRIO_RGB, 0, 0, 0, "blank");
      drive(0, 5'b11111, PRIO_RGB, 0, 0, 0, "blank");
      drive(1, 5'b11111, PRIO_RGB, 0, 0, 0, "blank");
      drive(0, 5'b11111, PRIO_RGB, 0, 0, 0, "blank");
      drive(1, 5'b01111, PRIO_RGB, 0, 0, 0, "blank");
      drive(1, 5'b00000, PRIO_RGB, 0, 0, 0, "blank");
      // Magenta key pixel on the top layer
      drive(1, 5'b10100, KEY_RGB, 0, 0, 0, "key");

      // Fade out: request coincides with a tick, extra request arrives mid-fade
      drive(1, 5'b00001, WHITE_RGB, 1, 1, 0, "fade_out");
      for (int f = 0; f < 18; f++)
         for (int k = 0; k < FRAME; k++)
            drive(1, 5'b00001, WHITE_RGB, k == 0, f == 3 && k == 2, 0, "fade_out");
      // Resume and request together in HOLD: only resume counts
      drive(1, 5'b00001, WHITE_RGB, 0, 1, 1, "hold");
      for (int f = 0; f < 18; f++)
         for (int k = 0; k < FRAME; k++)
            drive(1, 5'b00001, WHITE_RGB, k == 0, 0, 0, "fade_in");

      // IDLE: lone resume ignored, then req+resume starts a fade-out only
      drive(1, 5'b00001, WHITE_RGB, 0, 0, 1, "idle");
      drive(1, 5'b00001, WHITE_RGB, 0, 0, 0, "idle");
      drive(1, 5'b00001, WHITE_RGB, 0, 1, 1, "idle");

      // Run the fade down to level 6, then reset asynchronously mid-cycle
      reached = 1'b0;
      for (int k = 0; k < 400 && !reached; k++) begin
         drive(1, 5'b00001, WHITE_RGB, k % FRAME == 0, 0, 0, "fade_out");
         reached = (m_mode == 1 && m_level == 6);
      end
      if (!reached) begin
         n_cmp++; n_bad++;
         $display("FAIL level6_wait: got level=%0d required 6", m_level);
      end
      #2;
      clr = 1'b1;
      idle_inputs();
      pix_q.delete();
      flag_q.delete();
      #1;
      chk("async_rgb", px.rgb, 12'h000, 1'b1);
      chk("async_busy", {11'b0, px.fade_busy}, 12'h000, 1'b1);
      model_reset();
      @(posedge clk); #1 clr = 1'b0;
      for (int k = 0; k < 4; k++) drive(1, 5'b00001, GREY_RGB, 0, 0, 0, "post_reset");

      // Randomised traffic with occasional fade requests and resumes
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < LAYERS; i++) begin
            c = ($urandom_range(0, 9) == 0) ? 12'hF0F : 12'($urandom);
            rr[12*i +: 12] = c;
         end
         drive($urandom_range(0, 7) != 0, LAYERS'($urandom), rr, n % 5 == 0,
               $urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0, "rand");
      end

      for (int k = 0; k < 3; k++) drive(0, '0, '0, 0, 0, 0, "drain");
      repeat (4) @(posedge clk);
      #1;
      chk("queue_drain", 12'(pix_q.size() + flag_q.size()), 12'h000, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
